// File: rtl/song_sequencer_pkg.sv
// Shared state encoding, ROM entry layout and reserved codes for the song sequencer.
package song_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam int TONE_W  = 2;
    localparam int NOTE_W  = 3;
    localparam int LEN_W   = 2;
    localparam int ENTRY_W = TONE_W + NOTE_W + LEN_W;

    localparam logic [NOTE_W-1:0] NOTE_REST = 3'b111;
    localparam logic [TONE_W-1:0] TONE_END  = 2'b11;
    localparam logic [TONE_W-1:0] TONE_MID  = 2'b01;

    typedef struct packed {
        logic [TONE_W-1:0] tone;
        logic [NOTE_W-1:0] note;
        logic [LEN_W-1:0]  len;
    } song_entry_t;

    localparam logic [ENTRY_W-1:0] END_ENTRY = {TONE_END, NOTE_REST, 2'b00};

    function automatic logic is_end_marker(input song_entry_t e);
        return (e.tone == TONE_END);
    endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational song table: index -> {tone, note, len}. SONG_SEL 0 is the main
// melody, SONG_SEL 1 a short jingle; addresses past the tune read as end markers.
module song_rom
    import song_sequencer_pkg::*;
#(
    parameter int ROM_DEPTH = 32,
    parameter int SONG_SEL  = 0
) (
    input  logic [$clog2(ROM_DEPTH)-1:0] i_index,
    output logic [6:0]                   o_entry
);

    logic [5:0] w_addr;

    assign w_addr = 6'(i_index);

    // Table lookup; entry layout is {tone[1:0], note[2:0], len[1:0]}
    always_comb begin
        o_entry = END_ENTRY;
        if (SONG_SEL != 0) begin
            case (w_addr)
                6'd0:    o_entry = {2'b01, 3'b100, 2'b00};
                6'd1:    o_entry = {2'b10, 3'b000, 2'b01};
                6'd2:    o_entry = {2'b00, 3'b010, 2'b00};
                default: o_entry = END_ENTRY;
            endcase
        end else begin
            case (w_addr)
                6'd0:    o_entry = {2'b01, 3'b000, 2'b00};
                6'd1:    o_entry = {2'b01, 3'b010, 2'b10};
                6'd2:    o_entry = {2'b01, 3'b100, 2'b01};
                6'd3:    o_entry = {2'b10, 3'b001, 2'b00};
                6'd4:    o_entry = {2'b00, 3'b110, 2'b11};
                6'd5:    o_entry = {2'b01, 3'b011, 2'b01};
                6'd6:    o_entry = {2'b10, 3'b101, 2'b00};
                6'd7:    o_entry = {2'b01, 3'b000, 2'b10};
                default: o_entry = END_ENTRY;
            endcase
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: plays ROM entries beat by beat with GAP_BEATS rests after each note.
// Build option: define SONG_LOOP_EN to restart from entry 0 at the end instead of stopping in DONE.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int ROM_DEPTH = 32,
    parameter int GAP_BEATS = 1,
    parameter int SONG_SEL  = 0
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       beat_tick,
    input  logic       play_en,
    input  logic       pause,
    output logic [2:0] note_code,
    output logic [1:0] tone_out,
    output logic       busy,
    output logic       song_done
);

    localparam int                IDX_W    = $clog2(ROM_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROM_DEPTH - 1);
    localparam logic [LEN_W-1:0]  GAP_LOAD = (GAP_BEATS > 0) ? LEN_W'(GAP_BEATS - 1) : 2'b00;

    seq_state_e          r_state;
    seq_state_e          w_state_nxt;
    logic [IDX_W-1:0]    r_index;
    logic [IDX_W-1:0]    w_index_nxt;
    logic [IDX_W-1:0]    w_next_idx;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic [LEN_W-1:0]    w_beat_nxt;
    logic [NOTE_W-1:0]   r_note;
    logic [NOTE_W-1:0]   w_note_nxt;
    logic [TONE_W-1:0]   r_tone;
    logic [TONE_W-1:0]   w_tone_nxt;
    logic                r_busy;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_step;
    logic                w_restart;
    logic                w_last;
    logic [ENTRY_W-1:0]  w_first_raw;
    logic [ENTRY_W-1:0]  w_next_raw;
    song_entry_t         w_first;
    song_entry_t         w_next;

    assign w_next_idx = r_index + 1'b1;
    assign w_first    = w_first_raw;
    assign w_next     = w_next_raw;

    // Entry 0 is read on its own port so a loop restart can load it in the same cycle as the end check
    song_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .SONG_SEL  (SONG_SEL)
    ) u_rom_first (
        .i_index (LAST_IDX ^ LAST_IDX),
        .o_entry (w_first_raw)
    );

    song_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .SONG_SEL  (SONG_SEL)
    ) u_rom_next (
        .i_index (w_next_idx),
        .o_entry (w_next_raw)
    );

    // Next-state/next-output decode; entry loads requested by the state case are resolved afterwards
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_beat_nxt  = r_beat_cnt;
        w_note_nxt  = r_note;
        w_tone_nxt  = r_tone;
        w_done_nxt  = 1'b0;
        w_step      = 1'b0;
        w_restart   = 1'b0;
        w_last      = (r_index == LAST_IDX) || is_end_marker(w_next);

        if (!play_en) begin
            w_state_nxt = ST_IDLE;
            w_index_nxt = {IDX_W{1'b0}};
            w_beat_nxt  = 2'b00;
            w_note_nxt  = NOTE_REST;
            w_tone_nxt  = TONE_MID;
        end else if (pause) begin
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_restart = 1'b1;
                end
                ST_NOTE: begin
                    if (!beat_tick) begin
                        w_beat_nxt = r_beat_cnt;
                    end else if (r_beat_cnt != 2'b00) begin
                        w_beat_nxt = r_beat_cnt - 2'b01;
                    end else if (GAP_BEATS == 0) begin
                        w_step = 1'b1;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_beat_nxt  = GAP_LOAD;
                        w_note_nxt  = NOTE_REST;
                    end
                end
                ST_GAP: begin
                    if (!beat_tick) begin
                        w_beat_nxt = r_beat_cnt;
                    end else if (r_beat_cnt != 2'b00) begin
                        w_beat_nxt = r_beat_cnt - 2'b01;
                    end else begin
                        w_step = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Advance past the current entry: either the song ends or the next entry starts sounding now
        case ({w_step, w_last})
            2'b11: begin
                w_done_nxt = 1'b1;
`ifdef SONG_LOOP_EN
                w_restart  = 1'b1;
`else
                w_state_nxt = ST_DONE;
                w_note_nxt  = NOTE_REST;
`endif
            end
            2'b10: begin
                w_state_nxt = ST_NOTE;
                w_index_nxt = w_next_idx;
                w_beat_nxt  = w_next.len;
                w_note_nxt  = w_next.note;
                w_tone_nxt  = w_next.tone;
            end
            default: begin
                w_step = 1'b0;
            end
        endcase

        case ({w_restart, is_end_marker(w_first)})
            2'b11: begin
                w_state_nxt = ST_DONE;
                w_index_nxt = {IDX_W{1'b0}};
                w_note_nxt  = NOTE_REST;
                w_done_nxt  = 1'b1;
            end
            2'b10: begin
                w_state_nxt = ST_NOTE;
                w_index_nxt = {IDX_W{1'b0}};
                w_beat_nxt  = w_first.len;
                w_note_nxt  = w_first.note;
                w_tone_nxt  = w_first.tone;
            end
            default: begin
                w_restart = 1'b0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_index    <= {IDX_W{1'b0}};
            r_beat_cnt <= 2'b00;
            r_note     <= NOTE_REST;
            r_tone     <= TONE_MID;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_index    <= w_index_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_note     <= w_note_nxt;
            r_tone     <= w_tone_nxt;
            r_busy     <= (w_state_nxt == ST_NOTE) || (w_state_nxt == ST_GAP);
            r_done     <= w_done_nxt;
        end
    end

    assign note_code = r_note;
    assign tone_out  = r_tone;
    assign busy      = r_busy;
    assign song_done = r_done;

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter ROM_DEPTH, default 32, number of song entries; power of two, 4..64.
REQ-002 Parameter GAP_BEATS, default 1, rest beats inserted after every note; range 0..3.
REQ-003 sysclk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 beat_tick  input  1  one-cycle beat strobe from the playback divider; ignored when not 1 exactly on an edge.
REQ-006 play_en  input  1  auto-play switch level; 1 = run, 0 = stop and return to start.
REQ-007 pause  input  1  level; 1 = freeze position and outputs while play_en=1.
REQ-008 note_code  output  3  key code 0..6 for the buzzer, lattice and SMG stages; 3'b111 = silence.
REQ-009 tone_out  output  2  octave select 00 low, 01 mid, 10 high.
REQ-010 busy  output  1  1 while not in IDLE or DONE.
REQ-011 song_done  output  1  one-cycle pulse when the end marker is reached.

Function
REQ-012 The internal song ROM SHALL hold ROM_DEPTH entries of 7 bits: {tone[1:0], note[2:0], len[1:0]}; the note lasts len+1 beats (1..4).
REQ-013 An entry with tone=2'b11 SHALL be the end marker; an index reaching ROM_DEPTH-1 without a marker SHALL also count as end after that entry plays.
REQ-014 States: IDLE, NOTE, GAP, DONE.
REQ-015 IDLE: note_code=3'b111, tone_out=2'b01, index=0; on play_en=1 go to NOTE on the next edge with entry 0 loaded.
REQ-016 NOTE: outputs show the entry's note/tone from the first cycle in NOTE; beat counter decrements on each beat_tick; after len+1 ticks go to GAP (or directly to next NOTE if GAP_BEATS=0).
REQ-017 GAP: note_code=3'b111, tone_out unchanged; after GAP_BEATS ticks advance index and load the next entry into NOTE.
REQ-018 Loading an end-marker entry SHALL go to DONE, pulse song_done for exactly one cycle and drive note_code=3'b111.
REQ-019 DONE: hold silence until play_en=0 (then IDLE); behaviour with SONG_LOOP_EN per REQ-027.
REQ-020 play_en=0 in any state SHALL return to IDLE on the next edge, overriding beat_tick and pause.
REQ-021 pause=1 SHALL block beat counting and state transitions; outputs keep their values; beat_tick arriving during pause is dropped, not queued.
REQ-022 Beat counter SHALL be 2 bits, index log2(ROM_DEPTH) bits; no wrap other than REQ-013/REQ-027.
REQ-023 Output latency from ROM entry load to note_code valid SHALL be zero cycles (registered outputs updated on the same edge as the state change).

Reset
REQ-024 rst=1 SHALL force IDLE, index=0, beat counter=0, note_code=3'b111, tone_out=2'b01, busy=0, song_done=0 on the next edge, mid-song included.
REQ-025 rst SHALL have priority over all other inputs.

Configuration
REQ-026 Macro SONG_LOOP_EN selects looping.
REQ-027 With SONG_LOOP_EN defined, reaching the end SHALL still pulse song_done, then reload entry 0 and enter NOTE on the next edge without passing DONE; without it, the block stops in DONE per REQ-019.

Structure
REQ-028 A shared package SHALL hold the state enum, the NOTE_REST (3'b111) and TONE_END (2'b11) constants and the ROM entry field widths.
REQ-029 The song table SHALL be a sub-module song_rom (combinational index-to-entry lookup); the FSM stays in song_sequencer.

Verification
REQ-030 rst during NOTE at index 5 -> next edge note_code=3'b111, tone_out=01, busy=0; after release with play_en=1, entry 0 replays.
REQ-031 Entry {01,010,10}, GAP_BEATS=1, ticks every 4 cycles -> note_code=010 for 3 ticks, then 111 for 1 tick, then next entry.
REQ-032 pause=1 for 10 ticks mid-note -> note_code unchanged, note resumes with remaining beat count intact.
REQ-033 End marker at index 3 without SONG_LOOP_EN -> single song_done pulse, DONE, silence; play_en=0 -> IDLE.
REQ-034 Same with SONG_LOOP_EN -> song_done pulse, entry 0 note on the following edge, busy stays 1.
REQ-035 play_en dropped in GAP while beat_tick=1 -> IDLE next edge, no index advance.
